// File: rtl/pdp8_kw_pkg.sv
// pdp8_kw_pkg: shared types and constants for the KW8/I tick source.
// Holds the line-filter state encoding, prescaler width and rate encodings.
package pdp8_kw_pkg;

  localparam int unsigned KW_DIV_W = 20;

  typedef enum logic [1:0] {
    LO_STABLE = 2'd0,
    QUAL_HI   = 2'd1,
    HI_STABLE = 2'd2,
    QUAL_LO   = 2'd3
  } kw_filt_state_e;

  typedef enum logic [1:0] {
    KW_RATE_0 = 2'd0,
    KW_RATE_1 = 2'd1,
    KW_RATE_2 = 2'd2,
    KW_RATE_3 = 2'd3
  } kw_rate_e;

  // Map a rate select onto one of the four prescale divisors.
  function automatic logic [KW_DIV_W-1:0] kw_div_sel(
    input logic [1:0]          rate,
    input logic [KW_DIV_W-1:0] d0,
    input logic [KW_DIV_W-1:0] d1,
    input logic [KW_DIV_W-1:0] d2,
    input logic [KW_DIV_W-1:0] d3
  );
    logic [KW_DIV_W-1:0] d;
    case (kw_rate_e'(rate))
      KW_RATE_0: d = d0;
      KW_RATE_1: d = d1;
      KW_RATE_2: d = d2;
      default:   d = d3;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pdp8_kw_tick_if.sv
// pdp8_kw_tick_if: tick delivery handshake between the tick source (master)
// and the KW8/I counter (slave).
interface pdp8_kw_tick_if;

  logic tick;
  logic tick_req;
  logic overrun;
  logic tick_ack;
  logic ovr_clr;

  modport master (
    output tick,
    output tick_req,
    output overrun,
    input  tick_ack,
    input  ovr_clr
  );

  modport slave (
    input  tick,
    input  tick_req,
    input  overrun,
    output tick_ack,
    output ovr_clr
  );

endinterface

// File: rtl/pdp8_kw_line_filt.sv
// pdp8_kw_line_filt: 2-flop synchronizer plus debounce FSM for the external
// line-frequency input. Emits a registered 1-cycle pulse on each qualified
// rising edge. Only built when KW_EXT_LINE_EN is defined.
`ifdef KW_EXT_LINE_EN
module pdp8_kw_line_filt
  import pdp8_kw_pkg::*;
#(
  parameter logic [7:0] FILT = 8'd16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_in,
  output logic rise
);

  logic           s1;
  logic           s2;
  kw_filt_state_e state_q;
  kw_filt_state_e state_n;
  logic [7:0]     qcnt_q;
  logic [7:0]     qcnt_n;
  logic           rise_n;

  // Bring the asynchronous line input into the cpu clock domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= line_in;
      s2 <= s1;
    end
  end

  // Filter state, qualification counter and registered rise pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LO_STABLE;
      qcnt_q  <= '0;
      rise    <= 1'b0;
    end else begin
      state_q <= state_n;
      qcnt_q  <= qcnt_n;
      rise    <= rise_n;
    end
  end

  // Next-state: a level must hold FILT consecutive cycles to be accepted;
  // the entry cycle into a QUAL state counts as the first of them.
  always_comb begin
    state_n = state_q;
    qcnt_n  = qcnt_q;
    rise_n  = 1'b0;
    case (state_q)
      LO_STABLE: begin
        if (s2) begin
          if (FILT <= 8'd1) begin
            state_n = HI_STABLE;
            rise_n  = 1'b1;
          end else begin
            state_n = QUAL_HI;
            qcnt_n  = 8'd1;
          end
        end
      end
      QUAL_HI: begin
        if (!s2) begin
          state_n = LO_STABLE;
        end else if (qcnt_q >= FILT - 8'd1) begin
          state_n = HI_STABLE;
          rise_n  = 1'b1;
        end else begin
          qcnt_n = qcnt_q + 8'd1;
        end
      end
      HI_STABLE: begin
        if (!s2) begin
          if (FILT <= 8'd1) begin
            state_n = LO_STABLE;
          end else begin
            state_n = QUAL_LO;
            qcnt_n  = 8'd1;
          end
        end
      end
      QUAL_LO: begin
        if (s2) begin
          state_n = HI_STABLE;
        end else if (qcnt_q >= FILT - 8'd1) begin
          state_n = LO_STABLE;
        end else begin
          qcnt_n = qcnt_q + 8'd1;
        end
      end
      default: state_n = LO_STABLE;
    endcase
  end

endmodule
`endif

// File: rtl/pdp8_kw_tick.sv
// pdp8_kw_tick: KW8/I real-time clock tick source. Internal prescaler with
// four selectable divisors, optional external line-frequency source, and a
// req/ack tick handshake with sticky overrun.
// Build option: define KW_EXT_LINE_EN to build the line_in path and honour
// src_sel; otherwise line_in/src_sel are ignored.
module pdp8_kw_tick
  import pdp8_kw_pkg::*;
#(
  parameter logic [KW_DIV_W-1:0] DIV_0 = 20'd1000,
  parameter logic [KW_DIV_W-1:0] DIV_1 = 20'd10000,
  parameter logic [KW_DIV_W-1:0] DIV_2 = 20'd100000,
  parameter logic [KW_DIV_W-1:0] DIV_3 = 20'd1000000,
  parameter logic [7:0]          FILT  = 8'd16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  src_sel,
  input  logic [1:0]            rate,
  input  logic                  line_in,
  pdp8_kw_tick_if.master        kw
);

  logic [KW_DIV_W-1:0] div;
  logic [KW_DIV_W-1:0] pre_cnt;
  logic [1:0]          rate_q;
  logic                chg;
  logic                pre_ev;
  logic                ev;

  assign div    = kw_div_sel(rate, DIV_0, DIV_1, DIV_2, DIV_3);
  assign pre_ev = !chg && (pre_cnt == div - 1'b1);

`ifdef KW_EXT_LINE_EN
  logic src_q;
  logic line_ev;

  pdp8_kw_line_filt #(.FILT(FILT)) u_line_filt (
    .clk     (clk),
    .reset_n (reset_n),
    .line_in (line_in),
    .rise    (line_ev)
  );

  // Remember last cycle's source so a source switch restarts the prescaler.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) src_q <= 1'b0;
    else          src_q <= src_sel;
  end

  assign chg = (rate != rate_q) || (src_sel != src_q);
  assign ev  = enable && (src_sel ? line_ev : pre_ev);
`else
  logic unused_line;
  assign unused_line = line_in ^ src_sel ^ (|FILT);
  assign chg = (rate != rate_q);
  assign ev  = enable && pre_ev;
`endif

  // Prescaler: counts 0..div-1; held at 0 while disabled, restarted on a
  // rate/source change so no short period straddles the change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      rate_q  <= '0;
    end else begin
      rate_q <= rate;
      if (!enable || chg || pre_ev) pre_cnt <= '0;
      else                          pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Tick pulse, pending request and sticky overrun; set beats clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kw.tick     <= 1'b0;
      kw.tick_req <= 1'b0;
      kw.overrun  <= 1'b0;
    end else begin
      kw.tick <= ev;
      if (ev)               kw.tick_req <= 1'b1;
      else if (kw.tick_ack) kw.tick_req <= 1'b0;
      if (ev && kw.tick_req && !kw.tick_ack) kw.overrun <= 1'b1;
      else if (kw.ovr_clr)                   kw.overrun <= 1'b0;
    end
  end

endmodule
